// File: rtl/shift_reg_univ.sv
// Universal 4-mode shift register (hold / right / left / load) with a frame counter.
// frame_done pulses for one cycle after every WIDTH-th shift of the current frame.
module shift_reg_univ #(
   parameter int WIDTH = 8,
   parameter int CW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       mode,
   input  logic             sr_in,
   input  logic             sl_in,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] q,
   output logic             so_r,
   output logic             so_l,
   output logic [CW-1:0]    shift_cnt,
   output logic             frame_done
);

   localparam logic [1:0]    MODE_HOLD  = 2'b00;
   localparam logic [1:0]    MODE_RIGHT = 2'b01;
   localparam logic [1:0]    MODE_LEFT  = 2'b10;
   localparam logic [1:0]    MODE_LOAD  = 2'b11;
   localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);

   logic [WIDTH-1:0] r_q;
   logic [CW-1:0]    r_cnt;
   logic             r_frame_done;

   logic [WIDTH-1:0] w_q_nxt;
   logic [CW-1:0]    w_cnt_nxt;
   logic             w_frame_done_nxt;
   logic             w_shift;

   // Next-state: data path by mode, then the shared frame counter for either shift direction.
   always_comb begin
      w_q_nxt          = r_q;
      w_cnt_nxt        = r_cnt;
      w_frame_done_nxt = 1'b0;
      w_shift          = 1'b0;
      case (mode)
         MODE_HOLD: begin
            w_q_nxt = r_q;
         end
         MODE_RIGHT: begin
            w_q_nxt = {sr_in, r_q[WIDTH-1:1]};
            w_shift = 1'b1;
         end
         MODE_LEFT: begin
            w_q_nxt = {r_q[WIDTH-2:0], sl_in};
            w_shift = 1'b1;
         end
         MODE_LOAD: begin
            w_q_nxt   = d_in;
            w_cnt_nxt = CNT_ZERO;
         end
         default: begin
            w_q_nxt = r_q;
         end
      endcase

      if (w_shift) begin
         if (r_cnt == CNT_LAST) begin
            w_cnt_nxt        = CNT_ZERO;
            w_frame_done_nxt = 1'b1;
         end else begin
            w_cnt_nxt        = r_cnt + CNT_ONE;
            w_frame_done_nxt = 1'b0;
         end
      end else begin
         w_frame_done_nxt = 1'b0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q          <= {WIDTH{1'b0}};
         r_cnt        <= CNT_ZERO;
         r_frame_done <= 1'b0;
      end else begin
         r_q          <= w_q_nxt;
         r_cnt        <= w_cnt_nxt;
         r_frame_done <= w_frame_done_nxt;
      end
   end

   assign q          = r_q;
   assign so_r       = r_q[0];
   assign so_l       = r_q[WIDTH-1];
   assign shift_cnt  = r_cnt;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed self-checking bench for shift_reg_univ (WIDTH=8, CW=4).
module tb_shift_reg_univ;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] mode;
   logic       sr_in;
   logic       sl_in;
   logic [7:0] d_in;
   logic [7:0] q;
   logic       so_r;
   logic       so_l;
   logic [3:0] shift_cnt;
   logic       frame_done;

   int n_cmp = 0;
   int n_err = 0;

   shift_reg_univ #(.WIDTH(8), .CW(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode       (mode),
      .sr_in      (sr_in),
      .sl_in      (sl_in),
      .d_in       (d_in),
      .q          (q),
      .so_r       (so_r),
      .so_l       (so_l),
      .shift_cnt  (shift_cnt),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      mode = 2'b11; d_in = 8'hAA;
      tick();
      rst_n = 1'b0; mode = 2'b01;
      tick();
      n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL reset_q: got %h want 00", q); end
      n_cmp++; if (shift_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", shift_cnt); end
      n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_fd: got %b want 0", frame_done); end
      rst_n = 1'b1;
   endtask

   task automatic test_load();
      mode = 2'b11; d_in = 8'hA5;
      tick();
      n_cmp++; if (q !== 8'hA5) begin n_err++; $display("FAIL load_q: got %h want a5", q); end
      n_cmp++; if (so_r !== 1'b1) begin n_err++; $display("FAIL load_so_r: got %b want 1", so_r); end
      n_cmp++; if (so_l !== 1'b1) begin n_err++; $display("FAIL load_so_l: got %b want 1", so_l); end
      n_cmp++; if (shift_cnt !== 4'd0) begin n_err++; $display("FAIL load_cnt: got %0d want 0", shift_cnt); end
      d_in = 8'h5A;
      tick();
      n_cmp++; if ({so_l, so_r} !== 2'b00) begin n_err++; $display("FAIL load2_so: got %b want 00", {so_l, so_r}); end
   endtask

   task automatic test_right_frame();
      logic [7:0] seq;
      seq = 8'b1011_0010;
      do_reset();
      mode = 2'b01;
      for (int i = 0; i < 8; i++) begin
         sr_in = seq[7-i];
         tick();
         if (i < 7) begin
            n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL right_fd_early: step %0d got %b want 0", i, frame_done); end
            n_cmp++; if (shift_cnt !== 4'(i + 1)) begin n_err++; $display("FAIL right_cnt: step %0d got %0d want %0d", i, shift_cnt, i + 1); end
         end else begin
            n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL right_fd: got %b want 1", frame_done); end
            n_cmp++; if (shift_cnt !== 4'd0) begin n_err++; $display("FAIL right_cnt_end: got %0d want 0", shift_cnt); end
            n_cmp++; if (q !== 8'h4D) begin n_err++; $display("FAIL right_q: got %h want 4d", q); end
         end
      end
      mode = 2'b00;
      tick();
      n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL right_fd_drop: got %b want 0", frame_done); end
   endtask

   task automatic test_left_hold();
      int pulses;
      pulses = 0;
      mode = 2'b11; d_in = 8'h81;
      tick();
      mode = 2'b10; sl_in = 1'b0;
      tick();
      tick();
      n_cmp++; if (q !== 8'h04) begin n_err++; $display("FAIL left_q2: got %h want 04", q); end
      n_cmp++; if (shift_cnt !== 4'd2) begin n_err++; $display("FAIL left_cnt2: got %0d want 2", shift_cnt); end
      mode = 2'b00;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if ({q, shift_cnt, frame_done} !== {8'h04, 4'd2, 1'b0}) begin
            n_err++; $display("FAIL hold: step %0d got q=%h cnt=%0d fd=%b want 04/2/0", i, q, shift_cnt, frame_done);
         end
      end
      mode = 2'b10;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (frame_done === 1'b1) pulses++;
      end
      n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL left_fd: got %b want 1", frame_done); end
      n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL left_pulses: got %0d want 1", pulses); end
      n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL left_q_end: got %h want 00", q); end
      n_cmp++; if (shift_cnt !== 4'd0) begin n_err++; $display("FAIL left_cnt_end: got %0d want 0", shift_cnt); end
      mode = 2'b00;
      tick();
      n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL left_fd_drop: got %b want 0", frame_done); end
   endtask

   task automatic test_abort();
      int pulses;
      pulses = 0;
      do_reset();
      mode = 2'b01; sr_in = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      n_cmp++; if (shift_cnt !== 4'd5) begin n_err++; $display("FAIL abort_cnt5: got %0d want 5", shift_cnt); end
      mode = 2'b11; d_in = 8'h3C;
      tick();
      n_cmp++; if ({q, shift_cnt, frame_done} !== {8'h3C, 4'd0, 1'b0}) begin
         n_err++; $display("FAIL abort_load: got q=%h cnt=%0d fd=%b want 3c/0/0", q, shift_cnt, frame_done);
      end
      mode = 2'b01; sr_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (frame_done === 1'b1) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL abort_pulses: got %0d want 0", pulses); end
      n_cmp++; if (q !== 8'hF9) begin n_err++; $display("FAIL abort_q: got %h want f9", q); end
      n_cmp++; if (shift_cnt !== 4'd5) begin n_err++; $display("FAIL abort_cnt: got %0d want 5", shift_cnt); end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      mode = 2'b01; sr_in = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      rst_n = 1'b0;
      tick();
      n_cmp++; if ({q, shift_cnt, frame_done} !== {8'h00, 4'd0, 1'b0}) begin
         n_err++; $display("FAIL midrst: got q=%h cnt=%0d fd=%b want 00/0/0", q, shift_cnt, frame_done);
      end
      rst_n = 1'b1; mode = 2'b10; sl_in = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         n_cmp++; if (frame_done !== ((i == 7) || (i == 15))) begin
            n_err++; $display("FAIL b2b_fd: step %0d got %b want %b", i, frame_done, (i == 7) || (i == 15));
         end
      end
      n_cmp++; if (q !== 8'hFF) begin n_err++; $display("FAIL b2b_q: got %h want ff", q); end
   endtask

   task automatic test_dir_change();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         mode = (i % 2 == 0) ? 2'b01 : 2'b10;
         sr_in = 1'b1; sl_in = 1'b0;
         tick();
         if (i == 3) begin
            n_cmp++; if (shift_cnt !== 4'd4) begin n_err++; $display("FAIL dir_cnt: got %0d want 4", shift_cnt); end
         end else begin
            n_cmp++; if (frame_done !== (i == 7)) begin n_err++; $display("FAIL dir_fd: step %0d got %b want %b", i, frame_done, i == 7); end
         end
      end
   endtask

   initial begin
      rst_n = 1'b1; mode = 2'b00; sr_in = 1'b0; sl_in = 1'b0; d_in = 8'h00;
      test_reset();
      test_load();
      test_right_frame();
      test_left_hold();
      test_abort();
      test_reset_mid_frame();
      test_dir_change();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
